// File: rtl/mem_bus_bridge_if.sv
// Signal bundle between the MEM stage, the bridge and its DM/timer targets.
// master = bridge view, slave = the surrounding CPU/device view.
interface mem_bus_bridge_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        stall;
    logic [4:0]  excode;
    logic        dm_req;
    logic        dev_req;
    logic        dev_sel;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        dev_ack;
    logic [31:0] dev_rdata;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        input  dm_ack, dm_rdata, dev_ack, dev_rdata,
        output cpu_rdata, cpu_done, stall, excode,
        output dm_req, dev_req, dev_sel, bus_we, bus_addr, bus_be, bus_wdata
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_be, cpu_wdata,
        output dm_ack, dm_rdata, dev_ack, dev_rdata,
        input  cpu_rdata, cpu_done, stall, excode,
        input  dm_req, dev_req, dev_sel, bus_we, bus_addr, bus_be, bus_wdata
    );
endinterface

// File: rtl/mem_bus_bridge.sv
// MEM-stage load/store sequencer onto DM, timer 0 or timer 1 with address-error reporting.
// Optional BRIDGE_TIMEOUT_EN: abort a WAIT that sees no ack within TIMEOUT cycles.
module mem_bus_bridge #(
    parameter logic [31:0] DM_TOP    = 32'h0000_2fff,
    parameter logic [31:0] TMR0_BASE = 32'h0000_7f00,
    parameter logic [31:0] TMR1_BASE = 32'h0000_7f10
`ifdef BRIDGE_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT   = 16
`endif
) (
    input  logic               clk,
    input  logic               reset,
    mem_bus_bridge_if.master   bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e      state_q;
    logic [31:0] cpu_rdata_q, bus_addr_q, bus_wdata_q;
    logic [3:0]  bus_be_q;
    logic [4:0]  excode_q;
    logic        cpu_done_q, dm_req_q, dev_req_q, dev_sel_q, bus_we_q;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    logic [CNT_W-1:0] cnt_q;
`endif

    logic [31:0] off0, off1;
    logic        hit_dm, hit_t0, hit_t1, hit_tmr, misalign, acc_err, tgt_ack;
    logic [3:0]  tmr_off;
    logic [4:0]  err_code;

    // Offsets wrap to huge values below a base, so one unsigned compare bounds each window.
    always_comb begin
        off0     = bus.cpu_addr - TMR0_BASE;
        off1     = bus.cpu_addr - TMR1_BASE;
        hit_dm   = bus.cpu_addr <= DM_TOP;
        hit_t0   = off0 <= 32'd11;
        hit_t1   = off1 <= 32'd11;
        hit_tmr  = hit_t0 | hit_t1;
        tmr_off  = hit_t0 ? off0[3:0] : off1[3:0];
        misalign = ((bus.cpu_be == 4'hf) && (bus.cpu_addr[1:0] != 2'b00)) ||
                   (((bus.cpu_be == 4'b0011) || (bus.cpu_be == 4'b1100)) && bus.cpu_addr[0]);
        acc_err  = misalign || (hit_tmr && (bus.cpu_be != 4'hf)) ||
                   (hit_tmr && bus.cpu_we && (tmr_off == 4'h8)) || !(hit_dm || hit_tmr);
        err_code = bus.cpu_we ? 5'd5 : 5'd4;
        tgt_ack  = dm_req_q ? bus.dm_ack : bus.dev_ack;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cpu_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            excode_q    <= '0;
            dm_req_q    <= 1'b0;
            dev_req_q   <= 1'b0;
            dev_sel_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    cpu_done_q <= 1'b0;
                    excode_q   <= '0;
                    if (bus.cpu_req) begin
                        if (acc_err) begin
                            state_q     <= RESP;
                            cpu_done_q  <= 1'b1;
                            excode_q    <= err_code;
                            cpu_rdata_q <= '0;
                        end else begin
                            state_q     <= WAIT;
                            dm_req_q    <= hit_dm;
                            dev_req_q   <= hit_tmr;
                            dev_sel_q   <= hit_t1;
                            bus_we_q    <= bus.cpu_we;
                            bus_addr_q  <= bus.cpu_addr;
                            bus_be_q    <= bus.cpu_be;
                            bus_wdata_q <= bus.cpu_wdata;
`ifdef BRIDGE_TIMEOUT_EN
                            cnt_q       <= '0;
`endif
                        end
                    end
                end
                WAIT: begin
                    // An ack on the final counted cycle still completes the access.
                    if (tgt_ack) begin
                        state_q     <= RESP;
                        dm_req_q    <= 1'b0;
                        dev_req_q   <= 1'b0;
                        cpu_done_q  <= 1'b1;
                        excode_q    <= '0;
                        cpu_rdata_q <= bus_we_q ? 32'h0 : (dm_req_q ? bus.dm_rdata : bus.dev_rdata);
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q     <= RESP;
                        dm_req_q    <= 1'b0;
                        dev_req_q   <= 1'b0;
                        cpu_done_q  <= 1'b1;
                        excode_q    <= bus_we_q ? 5'd5 : 5'd4;
                        cpu_rdata_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                RESP: begin
                    state_q    <= IDLE;
                    cpu_done_q <= 1'b0;
                    excode_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.excode    = excode_q;
    assign bus.stall     = bus.cpu_req & ~cpu_done_q;
    assign bus.dm_req    = dm_req_q;
    assign bus.dev_req   = dev_req_q;
    assign bus.dev_sel   = dev_sel_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_be    = bus_be_q;
    assign bus.bus_wdata = bus_wdata_q;
endmodule

// File: tb/tb_mem_bus_bridge.sv
// Directed bench for mem_bus_bridge: vector table of single accesses plus hand-written
// sequences for wrong-target acks, long waits/timeouts, dropped requests and async reset.
module tb_mem_bus_bridge;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    mem_bus_bridge_if bif();
    mem_bus_bridge u_dut (.clk(clk), .reset(reset), .bus(bif));

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        int          ack_in;  // ack driven during this request cycle (1-based)
        logic [31:0] trd;     // data returned by the selected target
        logic [3:0]  tgt;     // {dm_req, dev_req, dev_sel, bus_we} while requesting
        int          nreq;    // cycles the target request stays high (0 = error)
        logic [4:0]  exc;
        logic [31:0] rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic access(input string tag, input vec_t v, input bit drop_req);
        int c = 0, nreq = 0, done_c = 0;
        bit seen = 0, stall_bad = 0;
        logic [3:0]  tgt = '0;
        logic [31:0] addr = '0, wd = '0, rd = '0;
        logic [3:0]  be = '0;
        logic [4:0]  exc = '0;
        @(posedge clk); #1;
        bif.cpu_req = 1'b1; bif.cpu_we = v.we; bif.cpu_addr = v.addr;
        bif.cpu_be = v.be; bif.cpu_wdata = v.wd;
        while (c < 64) begin
            @(posedge clk); #1; c++;
            bif.dm_ack = 1'b0; bif.dev_ack = 1'b0;
            if (bif.dm_req || bif.dev_req) begin
                nreq++;
                if (!seen) begin
                    seen = 1;
                    tgt  = {bif.dm_req, bif.dev_req, bif.dev_sel, bif.bus_we};
                    addr = bif.bus_addr; be = bif.bus_be; wd = bif.bus_wdata;
                end
                if (nreq == v.ack_in) begin
                    if (bif.dm_req) begin bif.dm_ack = 1'b1; bif.dm_rdata = v.trd; bif.dev_rdata = ~v.trd; end
                    else begin bif.dev_ack = 1'b1; bif.dev_rdata = v.trd; bif.dm_rdata = ~v.trd; end
                end
            end
            if (bif.cpu_done) begin
                done_c = c; rd = bif.cpu_rdata; exc = bif.excode;
                if (bif.stall) stall_bad = 1;
                break;
            end else if (bif.cpu_req && !bif.stall) stall_bad = 1;
            if (drop_req && c == 1) bif.cpu_req = 1'b0;
        end
        bif.cpu_req = 1'b0; bif.dm_ack = 1'b0; bif.dev_ack = 1'b0;
        chk({tag, " done_cycle"}, done_c, (v.nreq == 0) ? 1 : v.nreq + 1);
        chk({tag, " req_cycles"}, nreq, v.nreq);
        chk({tag, " target"}, {28'h0, tgt}, {28'h0, v.tgt});
        chk({tag, " excode"}, {27'h0, exc}, {27'h0, v.exc});
        chk({tag, " rdata"}, rd, v.rd);
        chk({tag, " stall"}, {31'h0, stall_bad}, 32'h0);
        if (v.nreq != 0) begin
            chk({tag, " bus_addr"}, addr, v.addr);
            chk({tag, " bus_be_wdata"}, {be, wd[27:0]}, {v.be, v.wd[27:0]});
        end
    endtask

    vec_t tbl[12];
    vec_t hv;

    initial begin
        bif.cpu_req = 0; bif.cpu_we = 0; bif.cpu_addr = 0; bif.cpu_be = 0; bif.cpu_wdata = 0;
        bif.dm_ack = 0; bif.dm_rdata = 0; bif.dev_ack = 0; bif.dev_rdata = 0;

        tbl[0]  = '{1'b0, 32'h0000_0100, 4'hf, 32'h0,         2, 32'hdeadbeef, 4'b1000, 2, 5'd0, 32'hdeadbeef};
        tbl[1]  = '{1'b1, 32'h0000_7f14, 4'hf, 32'h9,         1, 32'h55,       4'b0111, 1, 5'd0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0000_3000, 4'hf, 32'h0,         1, 32'h0,        4'b0000, 0, 5'd4, 32'h0};
        tbl[3]  = '{1'b1, 32'h0000_0102, 4'hf, 32'h1,         1, 32'h0,        4'b0000, 0, 5'd5, 32'h0};
        tbl[4]  = '{1'b1, 32'h0000_7f00, 4'b0001, 32'h1,      1, 32'h0,        4'b0000, 0, 5'd5, 32'h0};
        tbl[5]  = '{1'b1, 32'h0000_7f08, 4'hf, 32'h1,         1, 32'h0,        4'b0000, 0, 5'd5, 32'h0};
        tbl[6]  = '{1'b0, 32'h0000_7f08, 4'hf, 32'h0,         3, 32'h1234,     4'b0100, 3, 5'd0, 32'h1234};
        tbl[7]  = '{1'b0, 32'h0000_2ffe, 4'b1100, 32'h0,      1, 32'habcd0000, 4'b1000, 1, 5'd0, 32'habcd0000};
        tbl[8]  = '{1'b0, 32'h0000_0001, 4'b0011, 32'h0,      1, 32'h0,        4'b0000, 0, 5'd4, 32'h0};
        tbl[9]  = '{1'b0, 32'h0000_7f0c, 4'hf, 32'h0,         1, 32'h0,        4'b0000, 0, 5'd4, 32'h0};
        tbl[10] = '{1'b0, 32'h0000_7f18, 4'hf, 32'h0,         2, 32'h77,       4'b0110, 2, 5'd0, 32'h77};
        tbl[11] = '{1'b1, 32'h0000_2fff, 4'b1000, 32'h0f00_0000, 1, 32'h99,    4'b1001, 1, 5'd0, 32'h0};

        // Reset state
        #12;
        chk("rst dm_dev_sel_we", {28'h0, bif.dm_req, bif.dev_req, bif.dev_sel, bif.bus_we}, 32'h0);
        chk("rst cpu_rdata", bif.cpu_rdata, 32'h0);
        chk("rst done_exc_stall", {25'h0, bif.cpu_done, bif.excode, bif.stall}, 32'h0);
        chk("rst bus_addr", bif.bus_addr, 32'h0);
        chk("rst bus_wdata_be", bif.bus_wdata ^ {28'h0, bif.bus_be}, 32'h0);
        @(negedge clk); reset = 1'b1;

        for (int i = 0; i < 12; i++) access($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Acks from the non-selected timer must not complete a DM access
        @(posedge clk); #1;
        bif.cpu_req = 1; bif.cpu_we = 0; bif.cpu_addr = 32'h40; bif.cpu_be = 4'hf;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bif.dev_ack = 1; bif.dev_rdata = 32'hbad0bad0;
            chk("wrongack hold", {30'h0, bif.dm_req, bif.cpu_done}, 32'h2);
        end
        bif.dev_ack = 0; bif.dm_ack = 1; bif.dm_rdata = 32'h600d;
        @(posedge clk); #1;
        bif.dm_ack = 0;
        chk("wrongack done", {31'h0, bif.cpu_done}, 32'h1);
        chk("wrongack rdata", bif.cpu_rdata, 32'h600d);
        bif.cpu_req = 0;

        // Request dropped mid-WAIT still completes
        hv = '{1'b0, 32'h0000_0200, 4'hf, 32'h0, 3, 32'h3131, 4'b1000, 3, 5'd0, 32'h3131};
        access("dropreq", hv, 1'b1);

`ifdef BRIDGE_TIMEOUT_EN
        hv = '{1'b0, 32'h0000_0300, 4'hf, 32'h0, 100, 32'h7, 4'b1000, 16, 5'd4, 32'h0};
        access("timeout", hv, 1'b0);
        hv = '{1'b0, 32'h0000_0300, 4'hf, 32'h0, 16, 32'h7, 4'b1000, 16, 5'd0, 32'h7};
        access("ack_at_limit", hv, 1'b0);
`else
        hv = '{1'b0, 32'h0000_0300, 4'hf, 32'h0, 20, 32'h7, 4'b1000, 20, 5'd0, 32'h7};
        access("longwait", hv, 1'b0);
`endif

        // Asynchronous reset between edges while waiting on DM
        @(posedge clk); #1;
        bif.cpu_req = 1; bif.cpu_we = 0; bif.cpu_addr = 32'h84; bif.cpu_be = 4'hf;
        @(posedge clk); #1;
        chk("arst pre dm_req", {31'h0, bif.dm_req}, 32'h1);
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("arst dm_req", {31'h0, bif.dm_req}, 32'h0);
        chk("arst bus_addr", bif.bus_addr, 32'h0);
        chk("arst done", {31'h0, bif.cpu_done}, 32'h0);
        bif.cpu_req = 0;
        @(negedge clk); reset = 1'b1;
        access("post_rst", tbl[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
Sequences every MEM-stage load/store onto one of three targets: data memory, timer 0 or timer 1.
- Decodes the address and drives a req/ack handshake to the selected target.
- Holds the pipeline (stall) until the access completes.
- Reports address/alignment/access violations as excode 4 (load) or 5 (store) instead of issuing the access.
- Sits between the MEM pipeline register and the DM/timer devices.

Parameters:
DM_TOP, 32'h0000_2fff, highest valid DM byte address (DM spans 0..DM_TOP)
TMR0_BASE, 32'h0000_7f00, timer 0 base; registers at +0x0, +0x4, +0x8 (COUNT, read-only)
TMR1_BASE, 32'h0000_7f10, timer 1 base; same layout
TIMEOUT, 16, cycles in WAIT without ack before bus error (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cpu_req  in  1  MEM stage holds a valid load/store; held until cpu_done
cpu_we  in  1  1 = store, 0 = load
cpu_addr  in  32  byte address (AO_M)
cpu_be  in  4  byte enables, already aligned by MEM stage
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid with cpu_done
cpu_done  out  1  one-cycle completion pulse (success or error)
stall  out  1  freeze PC..MEM registers
excode  out  5  0 = ok, 4 = AdEL, 5 = AdES; valid with cpu_done
dm_req  out  1  DM request
dev_req  out  1  timer request
dev_sel  out  1  0 = timer 0, 1 = timer 1
bus_we  out  1  write strobe to selected target
bus_addr  out  32  forwarded address (timers use [3:2])
bus_be  out  4  forwarded byte enables
bus_wdata  out  32  forwarded write data
dm_ack  in  1  DM access complete
dm_rdata  in  32  DM read data
dev_ack  in  1  timer access complete
dev_rdata  in  32  timer read data

Behaviour:
- States: IDLE, WAIT, RESP. Reset (reset=0, async) forces IDLE and clears every output to 0, including cpu_rdata and the timeout counter.
- Decode in IDLE when cpu_req=1:
  - DM: addr <= DM_TOP.
  - TMR0: TMR0_BASE <= addr <= TMR0_BASE+0xb.
  - TMR1: same window for TMR1_BASE.
  - Any other address is invalid.
- Error checks in IDLE:
  - Misalignment: cpu_be==4'hf with addr[1:0]!=0, or a halfword be with addr[0]!=0.
  - Non-word access (be!=4'hf) to either timer.
  - Store to timer offset 0x8.
  - Invalid address.
  - On any error: no target request; next state RESP with excode = cpu_we ? 5 : 4.
- IDLE -> WAIT on a valid access:
  - Register bus_* outputs from cpu_*.
  - Assert dm_req, or dev_req with dev_sel.
  - Clear the counter.
- WAIT:
  - Request held high, bus_* stable.
  - Counter increments each cycle.
  - On ack from the selected target: capture rdata (0 for stores), drop request, go to RESP with excode 0.
  - Acks from the non-selected target are ignored.
  - Ack and counter==TIMEOUT-1 in the same cycle: ack wins.
- RESP: cpu_done=1 for exactly one cycle, then IDLE. A new request is accepted no earlier than the cycle after RESP.
- stall = cpu_req & ~cpu_done (combinational). cpu_done is 0 in IDLE, so an unserved request always stalls.
- Latency, success path: req seen at edge 0; target req high from edge 1; ack in cycle k; done pulse in cycle k+1.
- Latency, error path: done pulse in cycle 1.
- cpu_req dropping while in WAIT: the access still completes. cpu_done pulses and is ignored upstream.

Optional Feature:
BRIDGE_TIMEOUT_EN
- Defined: in WAIT, if the counter reaches TIMEOUT-1 with no ack, drop the request and go to RESP with excode 4 (load) or 5 (store); cpu_rdata = 0.
- Undefined: no counter logic; WAIT lasts until ack indefinitely.

Test Plan:
- Word load addr 0x0000_0100, dm_ack 2 cycles after dm_req, dm_rdata 0xdeadbeef -> dm_req high 2 cycles, cpu_done one cycle later, cpu_rdata 0xdeadbeef, excode 0, stall low same cycle as done.
- Word store addr 0x0000_7f14, be 4'hf, wdata 0x0000_0009 -> dev_req=1, dev_sel=1, bus_we=1, bus_addr 0x7f14; done after dev_ack, excode 0.
- Error cases, each done in cycle 1 with no dm_req/dev_req:
  - Load addr 0x0000_3000 -> excode 4.
  - Store be 4'hf at 0x0000_0102 -> excode 5.
  - sb-style be 4'b0001 to 0x7f00 -> excode 5.
  - Store to 0x7f08 -> excode 5.
- With BRIDGE_TIMEOUT_EN, TIMEOUT=16: load to DM, never ack -> dm_req high exactly 16 cycles, then done with excode 4, cpu_rdata 0. Repeat with ack on cycle 16 -> excode 0.
- Assert reset=0 mid-WAIT (asynchronously, between clock edges) -> dm_req, stall-related outputs and state clear immediately. After release, a fresh load completes normally.
